// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter
// between NUM_REQ byte streams, with burst cap and watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int BURST_MAX      = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int GNT_W = $clog2(NUM_REQ)
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_en,
  output logic [7:0]           tx_byte,
  input  logic                 tx_active,
  input  logic                 tx_finish,
  output logic [GNT_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BURST_END = BW'(BURST_MAX - 1);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [GNT_W-1:0] GNT_LAST = GNT_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_CAPTURE, S_START, S_WAIT
  } state_t;

  state_t           state, state_d;
  logic [GNT_W-1:0] grant_d;
  logic [GNT_W-1:0] last_grant, last_d;
  logic [BW-1:0]    burst_cnt, burst_d;
  logic             last_flag, lflag_d;
  logic [TW-1:0]    timer, timer_d;
  logic [7:0]       byte_d;
  logic             en_d;
  logic             err_set;
  logic             err_d;
  logic             fin;
  logic [GNT_W-1:0] rr_win, rr_idx;
  logic [7:0]       lane;

  assign busy = (state != S_IDLE);
  assign lane = req_data[{grant_id, 3'b000} +: 8];

  // Round-robin winner: nearest valid requester after last_grant.
  always_comb begin
    rr_win = last_grant;
    rr_idx = last_grant;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_idx = GNT_W'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[rr_idx]) rr_win = rr_idx;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state;
    grant_d   = grant_id;
    last_d    = last_grant;
    burst_d   = burst_cnt;
    lflag_d   = last_flag;
    timer_d   = timer;
    byte_d    = tx_byte;
    err_set   = 1'b0;
    fin       = 1'b0;
    req_ready = '0;
    unique case (state)
      S_IDLE: begin
        if (|req_valid) begin
          grant_d = rr_win;
          burst_d = '0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        req_ready[grant_id] = req_valid[grant_id];
        if (req_valid[grant_id]) begin
          byte_d  = lane;
          lflag_d = req_last[grant_id]
                  | (burst_cnt == BURST_END);
          burst_d = burst_cnt + BW'(1);
          timer_d = '0;
          state_d = S_START;
        end else begin
          last_d  = grant_id;
          state_d = S_IDLE;
        end
      end
      S_START, S_WAIT: begin
        timer_d = timer + TW'(1);
        fin = tx_finish
            & ((state == S_WAIT) | tx_active);
        if (fin) begin
          if (last_flag) begin
            last_d  = grant_id;
            state_d = S_IDLE;
          end else begin
            state_d = S_CAPTURE;
          end
        end else if (timer == TIMER_END) begin
          err_set = 1'b1;
          last_d  = grant_id;
          state_d = S_IDLE;
        end else if (state == S_START && tx_active) begin
          state_d = S_WAIT;
        end
      end
    endcase
    en_d  = (state == S_START) & (state_d == S_START);
    err_d = err_set | (timeout_err & ~err_clr);
  end

  // State and datapath registers; reset aborts any transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= S_IDLE;
      grant_id    <= '0;
      last_grant  <= GNT_LAST;
      burst_cnt   <= '0;
      last_flag   <= 1'b0;
      timer       <= '0;
      tx_byte     <= 8'h00;
      tx_en       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      grant_id    <= grant_d;
      last_grant  <= last_d;
      burst_cnt   <= burst_d;
      last_flag   <= lflag_d;
      timer       <= timer_d;
      tx_byte     <= byte_d;
      tx_en       <= en_d;
      timeout_err <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a queue-level
// arbitration model and a reactive transmitter model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int BM = 4;
  localparam int TO = 4096;
  localparam int GW = 2;

  logic           PCLK = 1'b0;
  logic           PRESETn;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           tx_en;
  logic [7:0]     tx_byte;
  logic           tx_active, tx_finish;
  logic [GW-1:0]  grant_id;
  logic           busy, timeout_err, err_clr;

  typedef struct {
    logic [7:0] d;
    bit         l;
  } item_t;

  typedef struct {
    logic [GW-1:0] g;
    logic [7:0]    d;
  } exp_t;

  item_t rq[N][$];
  exp_t  expq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ptr = N - 1;
  int ready_pulses = 0;
  int tx_pulses = 0;
  int en_rise_cyc = 0;
  logic [N-1:0] rdy_s = '0;
  logic [N-1:0] last_ready = '0;
  bit hang = 0;
  bit term_mode = 0;
  int fixed_dur = 0;

  uart_tx_arbiter #(
    .NUM_REQ(N), .BURST_MAX(BM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .tx_en(tx_en), .tx_byte(tx_byte),
    .tx_active(tx_active), .tx_finish(tx_finish),
    .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;
  always @(negedge PCLK) rdy_s <= req_ready;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, req);
    end
  endtask

  function automatic bit rq_empty();
    for (int i = 0; i < N; i++)
      if (rq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: round-robin over requester queues, each
  // grant draining until last flag, cap or empty queue.
  task automatic predict();
    item_t m[N][$];
    item_t it;
    int j, n;
    for (int i = 0; i < N; i++) m[i] = rq[i];
    while (1) begin
      bit any = 0;
      for (int i = 0; i < N; i++)
        if (m[i].size() > 0) any = 1;
      if (!any) break;
      j = ptr;
      for (int k = 0; k < N; k++) begin
        j = (j + 1) % N;
        if (m[j].size() > 0) break;
      end
      n = 0;
      while (m[j].size() > 0 && n < BM) begin
        it = m[j].pop_front();
        expq.push_back('{g: GW'(j), d: it.d});
        n++;
        if (it.l) break;
      end
      ptr = j;
    end
  endtask

  // Requester driver: pop accepted bytes, present fronts.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(posedge PCLK);
      #1;
      for (int i = 0; i < N; i++)
        if (rdy_s[i] && rq[i].size() > 0) rq[i].delete(0);
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() > 0) begin
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = rq[i][0].d;
          req_last[i]       = rq[i][0].l;
        end else begin
          req_valid[i]      = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]       = 1'b0;
        end
      end
    end
  end

  // Transmitter model: active one cycle after tx_en,
  // finish pulse a few cycles later (or never / terminal).
  initial begin
    int cnt, dur;
    bit on;
    tx_active = 0;
    tx_finish = 0;
    on = 0;
    cnt = 0;
    dur = 1;
    forever begin
      @(posedge PCLK);
      #1;
      tx_finish = 0;
      if (!PRESETn || (on && !busy)) begin
        on = 0;
        tx_active = 0;
      end else if (!on) begin
        if (tx_en) begin
          on = 1;
          cnt = 0;
          dur = (fixed_dur > 0) ? fixed_dur
                                : $urandom_range(1, 4);
        end
      end else begin
        cnt++;
        if (cnt == 1) tx_active = 1;
        if (term_mode ? (cnt == TO - 3)
                      : (!hang && cnt == dur + 1)) begin
          tx_finish = 1;
          tx_active = 0;
          on = 0;
        end
      end
    end
  end

  // Monitor: each tx_en rise is a transfer to score.
  initial begin
    logic prev_en;
    exp_t e;
    prev_en = 0;
    forever begin
      @(negedge PCLK);
      if (req_ready != '0) begin
        ready_pulses++;
        last_ready = req_ready;
        checks++;
        if ($countones(req_ready) != 1 || !busy) begin
          errors++;
          $display("FAIL ready_onehot: got %b busy=%b",
                   req_ready, busy);
        end
      end
      if (tx_en && !prev_en) begin
        tx_pulses++;
        en_rise_cyc = cyc;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: grant %0d byte %h",
                   grant_id, tx_byte);
        end else begin
          e = expq.pop_front();
          chk("tx_grant", 32'(grant_id), 32'(e.g));
          chk("tx_byte", 32'(tx_byte), 32'(e.d));
        end
      end
      prev_en = tx_en;
    end
  end

  task automatic drain(string nm, int limit);
    int k = 0;
    while ((expq.size() > 0 || !rq_empty() || busy)
           && k < limit) begin
      @(negedge PCLK);
      k++;
    end
    checks++;
    if (k >= limit) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d pending",
               nm, expq.size());
    end
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    #1;
    PRESETn = 0;
    for (int i = 0; i < N; i++) rq[i].delete();
    expq.delete();
    ptr = N - 1;
    hang = 0;
    term_mode = 0;
    repeat (3) @(negedge PCLK);
    PRESETn = 1;
  endtask

  initial begin
    int l0, p0, t0, k;
    err_clr = 0;
    PRESETn = 0;
    repeat (3) @(negedge PCLK);
    chk("rst_tx_en", 32'(tx_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_byte", 32'(tx_byte), 0);
    PRESETn = 1;

    // single byte on lane 2
    @(negedge PCLK);
    #1;
    fixed_dur = 20;
    p0 = ready_pulses;
    l0 = cyc;
    rq[2].push_back('{d: 8'hA5, l: 1'b1});
    predict();
    k = 0;
    while (!tx_finish && k < 100) begin
      @(posedge PCLK);
      #2;
      k++;
    end
    chk("t1_finish_seen", 32'(tx_finish), 1);
    @(posedge PCLK);
    @(negedge PCLK);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_latency", 32'(en_rise_cyc - l0), 4);
    chk("t1_ready_val", 32'(last_ready), 32'h4);
    chk("t1_ready_cnt", 32'(ready_pulses - p0), 1);
    chk("t1_grant_hold", 32'(grant_id), 2);
    fixed_dur = 0;

    // fairness: all four requesting, two bytes each
    do_reset();
    @(negedge PCLK);
    #1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        rq[i].push_back('{d: 8'($urandom), l: 1'b1});
    predict();
    drain("t2_fair", 500);

    // burst of three from requester 1, 3 also waiting
    @(negedge PCLK);
    #1;
    rq[1].push_back('{d: 8'h11, l: 1'b0});
    rq[1].push_back('{d: 8'h22, l: 1'b0});
    rq[1].push_back('{d: 8'h33, l: 1'b1});
    rq[3].push_back('{d: 8'h5C, l: 1'b1});
    predict();
    drain("t3_burst", 500);

    // burst cap: six unterminated bytes from requester 0
    @(negedge PCLK);
    #1;
    for (int i = 0; i < 6; i++)
      rq[0].push_back('{d: 8'(8'h40 + i), l: 1'b0});
    rq[1].push_back('{d: 8'h9E, l: 1'b1});
    predict();
    drain("t4_cap", 500);

    // randomized rounds
    for (int r = 0; r < 12; r++) begin
      @(negedge PCLK);
      #1;
      for (int i = 0; i < N; i++) begin
        int len = $urandom_range(0, 5);
        for (int b = 0; b < len; b++)
          rq[i].push_back('{d: 8'($urandom),
                           l: ($urandom_range(0, 2) == 0)});
      end
      predict();
      drain("rand_round", 1000);
    end

    // withdrawal during CAPTURE
    @(negedge PCLK);
    #1;
    p0 = ready_pulses;
    t0 = tx_pulses;
    rq[1].push_back('{d: 8'h77, l: 1'b1});
    @(posedge PCLK);
    @(negedge PCLK);
    #1;
    rq[1].delete();
    @(negedge PCLK);
    chk("wd_in_capture", 32'(busy), 1);
    @(negedge PCLK);
    chk("wd_back_idle", 32'(busy), 0);
    repeat (4) @(negedge PCLK);
    chk("wd_no_ready", 32'(ready_pulses - p0), 0);
    chk("wd_no_tx", 32'(tx_pulses - t0), 0);
    ptr = 1;
    #1;
    rq[1].push_back('{d: 8'h61, l: 1'b1});
    rq[2].push_back('{d: 8'h62, l: 1'b1});
    predict();
    drain("wd_after", 500);

    // watchdog: transmitter never finishes
    @(negedge PCLK);
    #1;
    hang = 1;
    rq[2].push_back('{d: 8'hC3, l: 1'b1});
    predict();
    k = 0;
    while (!timeout_err && k < TO + 100) begin
      @(negedge PCLK);
      k++;
    end
    chk("to_flag", 32'(timeout_err), 1);
    chk("to_latency", 32'(cyc - en_rise_cyc), 32'(TO - 2));
    chk("to_idle", 32'(busy), 0);
    chk("to_tx_en", 32'(tx_en), 0);
    hang = 0;
    repeat (3) @(negedge PCLK);
    chk("to_sticky", 32'(timeout_err), 1);
    #1;
    err_clr = 1;
    @(negedge PCLK);
    #1;
    err_clr = 0;
    @(negedge PCLK);
    chk("to_cleared", 32'(timeout_err), 0);
    drain("to_drain", 200);

    // finish on the terminal cycle wins over the watchdog
    @(negedge PCLK);
    #1;
    term_mode = 1;
    rq[3].push_back('{d: 8'h3C, l: 1'b1});
    predict();
    drain("term_drain", TO + 200);
    chk("term_no_err", 32'(timeout_err), 0);
    term_mode = 0;

    // reset in WAIT, then requester 0 has priority
    @(negedge PCLK);
    #1;
    hang = 1;
    rq[1].push_back('{d: 8'hE1, l: 1'b1});
    predict();
    k = 0;
    while (!tx_active && k < 50) begin
      @(negedge PCLK);
      k++;
    end
    chk("rw_active", 32'(tx_active), 1);
    repeat (3) @(negedge PCLK);
    #1;
    PRESETn = 0;
    #1;
    chk("rw_tx_en", 32'(tx_en), 0);
    chk("rw_busy", 32'(busy), 0);
    chk("rw_scored", 32'(expq.size()), 0);
    for (int i = 0; i < N; i++) rq[i].delete();
    expq.delete();
    ptr = N - 1;
    hang = 0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1;
    @(negedge PCLK);
    #1;
    rq[3].push_back('{d: 8'hD3, l: 1'b1});
    rq[0].push_back('{d: 8'hD0, l: 1'b1});
    predict();
    drain("rw_after", 500);

    chk("pulse_balance", 32'(ready_pulses), 32'(tx_pulses));
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters, e.g. APB register path, GPIO event logger and debug console.
- Grants the transmitter round-robin and sequences each byte: capture, start, then wait for finish.
- Limits each grant to a burst of at most BURST_MAX bytes.
- A watchdog flags a transmitter that never finishes.
- Sits between the requesters and the UART transmitter's enable/byte/active/finish interface, in the PCLK domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); GNT_W = clog2(NUM_REQ).
- BURST_MAX, 4, maximum bytes sent per grant before re-arbitration (>=1).
- TIMEOUT_CYCLES, 4096, PCLK cycles allowed from start to tx_finish (>=4).

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  requester i has a byte on its data lane.
- req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- req_last  in  NUM_REQ  requester i's current byte ends its burst.
- req_ready  out  NUM_REQ  byte of requester i accepted this cycle.
- tx_en  out  1  start request to the transmitter.
- tx_byte  out  8  byte to transmit, stable from START until the next capture.
- tx_active  in  1  transmitter is shifting.
- tx_finish  in  1  single-cycle pulse when the stop bit is complete.
- grant_id  out  GNT_W  current/last granted requester.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky watchdog flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (async, PRESETn=0): state=IDLE; tx_en=0, tx_byte=0, req_ready=0, grant_id=0, busy=0, timeout_err=0; last_grant=NUM_REQ-1 (requester 0 wins first); burst_cnt=0, timer=0.
- Reset mid-operation aborts the transfer immediately. No partial state survives; tx_en drops asynchronously.
- Round-robin: search req_valid starting at (last_grant+1) mod NUM_REQ, wrapping; first set bit wins.
- IDLE: busy=0. If any req_valid is set at the clock edge, grant_id<=winner, burst_cnt<=0, go to CAPTURE.
- CAPTURE:
  - req_ready[grant_id]=req_valid[grant_id] (combinational); all other ready bits are 0.
  - If valid: tx_byte<=lane data; last_flag<=req_last | (burst_cnt==BURST_MAX-1); burst_cnt++; timer<=0; go to START.
  - If not valid (requester withdrew): last_grant<=grant_id, go to IDLE. No byte is consumed.
- START:
  - tx_en=1 (registered, high for every cycle in START).
  - On a clock edge with tx_active=1: go to WAIT. If tx_finish is also set on that edge, it is treated as finish (see WAIT).
- WAIT:
  - tx_en=0. On tx_finish: if last_flag, last_grant<=grant_id and go to IDLE; else go to CAPTURE, same grant.
- Timing:
  - timer increments every cycle in START and WAIT.
  - Minimum latency: req_valid sampled at edge 0 (IDLE), CAPTURE at edge 1, tx_en high after edge 2.
  - Back-to-back bytes within a burst: tx_finish at edge n, tx_en high after edge n+2.
- Watchdog:
  - If timer reaches TIMEOUT_CYCLES-1 in START or WAIT without tx_finish: timeout_err<=1, tx_en<=0, last_grant<=grant_id, go to IDLE.
  - tx_finish on the same edge as the terminal count: finish wins, no error.
- err_clr: clears timeout_err. A set and a clear on the same edge resolve as set.
- tx_finish or tx_active outside START/WAIT: ignored.
- Burst cap: after BURST_MAX bytes the arbiter returns to IDLE even if req_last was never set. The requester's next byte competes again.
- grant_id holds its value in IDLE; it is not cleared.
- Only one req_ready bit is ever high, and only in CAPTURE. Exactly one byte is accepted per req_ready pulse.

Test Plan:
1. Single byte: req_valid[2]=1, req_data lane2=8'hA5, req_last[2]=1.
   - Requires grant_id=2, req_ready=4'b0100 for one cycle, tx_en high 2 cycles after request, tx_byte=8'hA5.
   - Model tx_active asserted 1 cycle later and tx_finish 20 cycles later; then busy=0 the cycle after finish.
2. Fairness: all four req_valid held high with req_last=1, 8 transfers.
   - Required grant order 0,1,2,3,0,1,2,3.
3. Burst: requester 1 supplies bytes 8'h11, 8'h22, 8'h33 with req_last only on 8'h33, while requester 3 is also requesting.
   - Requires three consecutive tx_en pulses on requester 1 (tx_byte 11, 22, 33), then grant_id=3.
4. Burst cap: requester 0 streams 6 bytes, req_last=0, with requester 1 also valid.
   - Requires 4 bytes from requester 0, then requester 1, then the remaining 2 from requester 0.
5. Watchdog: tx_active=1 with no tx_finish.
   - Requires timeout_err=1 exactly TIMEOUT_CYCLES-1 cycles after START entry, state IDLE, tx_en=0.
   - err_clr=1 for one cycle then clears the flag. Repeat with tx_finish on the terminal cycle: requires timeout_err to stay 0.
6. Reset and withdrawal:
   - PRESETn pulled low mid-WAIT: requires tx_en=0 and busy=0 immediately; after release, requester 0 has priority.
   - Requester withdraws req_valid during CAPTURE: requires no req_ready pulse, a return to IDLE, and no tx_en pulse.
